// File: rtl/sum_accumulator_pkg.sv
// Shared definitions for the sum_accumulator block: FSM state encoding and
// default widths used by the top and its adder.
package sum_accumulator_pkg;

    localparam int DEFAULT_NUM_BITS = 4;
    localparam int DEFAULT_NUM_OPS  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/adder_nbit.sv
// Parameterised combinational ripple-carry adder; carry-out is reported on
// the overflow port, matching the port naming of the 4-bit variant.
module adder_nbit #(
    parameter int NUM_BITS = 4
) (
    input  logic [NUM_BITS-1:0] a,
    input  logic [NUM_BITS-1:0] b,
    input  logic                carry_in,
    output logic [NUM_BITS-1:0] sum,
    output logic                overflow
);

    always_comb begin
        logic carry;
        carry = carry_in;
        sum   = '0;
        for (int i = 0; i < NUM_BITS; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        overflow = carry;
    end

endmodule

// File: rtl/sum_accumulator.sv
// Batch accumulator: sums NUM_OPS operands from a valid/ready stream through a
// ripple adder, flags any carry-out as sticky overflow, pulses done at the end.
module sum_accumulator
    import sum_accumulator_pkg::*;
#(
    parameter int NUM_BITS = DEFAULT_NUM_BITS,
    parameter int NUM_OPS  = DEFAULT_NUM_OPS
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             in_valid,
    input  logic [NUM_BITS-1:0]              in_data,
    output logic                             in_ready,
    output logic                             busy,
    output logic                             done,
    output logic [NUM_BITS-1:0]              result,
    output logic                             overflow,
    output logic [$clog2(NUM_OPS+1)-1:0]     op_count
);

    localparam int               CNT_W   = $clog2(NUM_OPS + 1);
    localparam logic [CNT_W-1:0] LAST_OP = CNT_W'(NUM_OPS - 1);

    state_t              state;
    logic                accept;
    logic [NUM_BITS-1:0] add_sum;
    logic                add_carry;

    adder_nbit #(
        .NUM_BITS (NUM_BITS)
    ) u_adder (
        .a        (result),
        .b        (in_data),
        .carry_in (1'b0),
        .sum      (add_sum),
        .overflow (add_carry)
    );

    // Handshake outputs decode from the state register only.
    assign in_ready = (state == ACCUM);
    assign done     = (state == DONE);
    assign accept   = in_valid & in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            result   <= '0;
            overflow <= 1'b0;
            op_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ACCUM;
                        busy     <= 1'b1;
                        result   <= '0;
                        overflow <= 1'b0;
                        op_count <= '0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        result   <= add_sum;
                        overflow <= overflow | add_carry;
                        op_count <= op_count + CNT_W'(1);
                        if (op_count == LAST_OP) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    // Results stay held in IDLE until the next start.
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench for sum_accumulator: directed scenarios plus random
// batches, compared against an integer-sum reference of each batch.
module tb_sum_accumulator;

    localparam int NB  = 4;
    localparam int NO  = 4;
    localparam int CW  = $clog2(NO + 1);
    localparam int MOD = 1 << NB;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic          in_valid;
    logic [NB-1:0] in_data;
    logic          in_ready;
    logic          busy;
    logic          done;
    logic [NB-1:0] result;
    logic          overflow;
    logic [CW-1:0] op_count;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    sum_accumulator #(
        .NUM_BITS (NB),
        .NUM_OPS  (NO)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .overflow (overflow),
        .op_count (op_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Called at a negedge while IDLE; returns at the negedge inside ACCUM.
    task automatic begin_batch();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("entry_busy", busy, 1);
        check("entry_ready", in_ready, 1);
        check("entry_done", done, 0);
        check("entry_result", result, 0);
        check("entry_ovf", overflow, 0);
        check("entry_count", op_count, 0);
    endtask

    task automatic feed(input logic [NB-1:0] v, input int gap);
        for (int g = 0; g < gap; g++) begin
            in_valid = 1'b0;
            in_data  = NB'($urandom);
            check("gap_ready", in_ready, 1);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_data  = v;
        check("accept_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Called at the negedge after the final accept (DONE state).
    task automatic check_done(input int total);
        check("done_pulse", done, 1);
        check("done_busy", busy, 1);
        check("done_ready", in_ready, 0);
        check("done_result", result, total % MOD);
        check("done_ovf", overflow, (total >= MOD) ? 1 : 0);
        check("done_count", op_count, NO);
        @(negedge clk);
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
        check("idle_ready", in_ready, 0);
        check("idle_result", result, total % MOD);
        check("idle_ovf", overflow, (total >= MOD) ? 1 : 0);
        check("idle_count", op_count, NO);
    endtask

    task automatic do_batch(input logic [NB-1:0] v0, input logic [NB-1:0] v1,
                            input logic [NB-1:0] v2, input logic [NB-1:0] v3,
                            input int g0, input int g1, input int g2, input int g3);
        logic [NB-1:0] v[4];
        int            g[4];
        int            total;
        v     = '{v0, v1, v2, v3};
        g     = '{g0, g1, g2, g3};
        total = 0;
        begin_batch();
        for (int k = 0; k < NO; k++) begin
            feed(v[k], g[k]);
            total += int'(v[k]);
            if (k < NO - 1) begin
                check("part_count", op_count, k + 1);
                check("part_result", result, total % MOD);
                check("part_ovf", overflow, (total >= MOD) ? 1 : 0);
                check("part_done", done, 0);
            end
        end
        check_done(total);
    endtask

    initial begin
        int total;
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (2) @(negedge clk);
        check("rst_result", result, 0);
        check("rst_ovf", overflow, 0);
        check("rst_count", op_count, 0);
        check("rst_ready", in_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;

        // IDLE ignores in_valid.
        in_valid = 1'b1;
        in_data  = 4'd5;
        @(negedge clk);
        in_valid = 1'b0;
        check("idle_ign_result", result, 0);
        check("idle_ign_count", op_count, 0);
        check("idle_ign_busy", busy, 0);

        // Back-to-back 1,2,3,4.
        do_batch(4'd1, 4'd2, 4'd3, 4'd4, 0, 0, 0, 0);
        // Sticky overflow through carry-free additions.
        do_batch(4'd8, 4'd8, 4'd0, 4'd1, 0, 0, 0, 0);
        // Gapped input: 5,_,_,3,_,2,7.
        do_batch(4'd5, 4'd3, 4'd2, 4'd7, 0, 2, 1, 0);

        // start during ACCUM is ignored.
        begin_batch();
        feed(4'd3, 0);
        feed(4'd4, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("acc_start_count", op_count, 2);
        check("acc_start_result", result, 7);
        check("acc_start_ready", in_ready, 1);
        feed(4'd1, 0);
        feed(4'd1, 0);
        check_done(9);

        // Reset mid-batch discards it.
        begin_batch();
        feed(4'd15, 0);
        feed(4'd15, 0);
        check("pre_rst_ovf", overflow, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_result", result, 0);
        check("mid_rst_ovf", overflow, 0);
        check("mid_rst_count", op_count, 0);
        check("mid_rst_ready", in_ready, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        do_batch(4'd0, 4'd0, 4'd0, 4'd0, 0, 0, 0, 0);

        // start held high across DONE: one-cycle DONE, then IDLE restarts.
        begin_batch();
        feed(4'd2, 0);
        feed(4'd3, 0);
        feed(4'd4, 0);
        start = 1'b1;
        feed(4'd6, 0);
        check_done(15);
        @(negedge clk);
        start = 1'b0;
        check("restart_busy", busy, 1);
        check("restart_ready", in_ready, 1);
        check("restart_result", result, 0);
        check("restart_count", op_count, 0);
        total = 0;
        for (int k = 0; k < NO; k++) begin
            logic [NB-1:0] r;
            r = NB'($urandom);
            feed(r, int'($urandom_range(0, 2)));
            total += int'(r);
        end
        check_done(total);

        // Random batches with random gaps.
        for (int b = 0; b < 20; b++) begin
            do_batch(NB'($urandom), NB'($urandom), NB'($urandom), NB'($urandom),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                     int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
